ss_scan_mux: RTL and testbench

SS_SCAN_MUX -- requirements
Module: ss_scan_mux

---
 rtl/ss_pkg.sv | 40 ++++
 rtl/ss_seg_rom.sv | 44 ++++
 rtl/ss_scan_mux.sv | 129 ++++++++++++
 tb/tb_ss_scan_mux.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan multiplexer: segment bit positions,
// digit glyph patterns (active-low, segments g..a) and a counter-width helper.
package ss_pkg;

  localparam int unsigned SEG_BIT_A  = 0;
  localparam int unsigned SEG_BIT_B  = 1;
  localparam int unsigned SEG_BIT_C  = 2;
  localparam int unsigned SEG_BIT_D  = 3;
  localparam int unsigned SEG_BIT_E  = 4;
  localparam int unsigned SEG_BIT_F  = 5;
  localparam int unsigned SEG_BIT_G  = 6;
  localparam int unsigned SEG_BIT_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Glyphs hold segments g..a only; the dp bit is merged separately.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;

  // Bits needed to count 0..range-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range <= 2) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/ss_seg_rom.sv
// Combinational nibble-to-segment decoder. Codes 10..15 show A..F only when SS_HEX_EN
// is defined; otherwise they blank while the decimal point still follows dp_i.
module ss_seg_rom
  import ss_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_OFF;
    case (code_i)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
`ifdef SS_HEX_EN
      4'd10:   glyph = SEG_A;
      4'd11:   glyph = SEG_B;
      4'd12:   glyph = SEG_C;
      4'd13:   glyph = SEG_D;
      4'd14:   glyph = SEG_E;
      4'd15:   glyph = SEG_F;
`endif
      default: glyph = SEG_OFF;
    endcase
  end

  always_comb begin
    seg_o                        = SEG_BLANK;
    seg_o[SEG_BIT_G:SEG_BIT_A]   = glyph;
    seg_o[SEG_BIT_DP]            = ~dp_i;
  end

endmodule

// File: rtl/ss_scan_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous double buffering.
// Optional hex glyphs for codes 10..15 are enabled by defining SS_HEX_EN.
module ss_scan_mux
  import ss_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [7:0]              sseg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int unsigned CntW = cnt_width(REFRESH_DIV);
  localparam int unsigned IdxW = cnt_width(NUM_DIGITS);

  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankCyc = CntW'(BLANK_CYC);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         div_q, div_d;
  logic [IdxW-1:0]         dig_q, dig_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    pend_q, pend_d;
  logic [7:0]              sseg_q, sseg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic       slot_end;
  logic       frame_end;
  logic       blank;
  logic [3:0] cur_code;
  logic       cur_dp;
  logic [7:0] rom_seg;

  assign slot_end  = (div_q == CntMax);
  assign frame_end = slot_end && (dig_q == IdxMax);
  assign blank     = (div_q < BlankCyc);
  assign cur_code  = act_data_q[{dig_q, 2'b00} +: 4];
  assign cur_dp    = act_dp_q[dig_q];

  ss_seg_rom u_seg_rom (
    .code_i (cur_code),
    .dp_i   (cur_dp),
    .seg_o  (rom_seg)
  );

  always_comb begin
    div_d = slot_end ? '0 : div_q + 1'b1;
    dig_d = dig_q;
    if (slot_end) begin
      dig_d = (dig_q == IdxMax) ? '0 : dig_q + 1'b1;
    end
  end

  // Loads land in the shadow and are promoted only at a frame boundary, so a frame
  // never mixes old and new digits; a load on the boundary itself goes straight through.
  always_comb begin
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    pend_d     = pend_q;
    if (load_i && frame_end) begin
      act_data_d = data_i;
      act_dp_d   = dp_i;
      pend_d     = 1'b0;
    end else if (load_i) begin
      sh_data_d = data_i;
      sh_dp_d   = dp_i;
      pend_d    = 1'b1;
    end else if (frame_end && pend_q) begin
      act_data_d = sh_data_q;
      act_dp_d   = sh_dp_q;
      pend_d     = 1'b0;
    end
  end

  always_comb begin
    an_d = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = blank || (dig_q != IdxW'(i));
    end
    sseg_d  = blank ? SEG_BLANK : rom_seg;
    frame_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      dig_q      <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      pend_q     <= 1'b0;
      sseg_q     <= SEG_BLANK;
      an_q       <= '1;
      frame_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      dig_q      <= dig_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      pend_q     <= pend_d;
      sseg_q     <= sseg_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign sseg_o    = sseg_q;
  assign an_o      = an_q;
  assign frame_o   = frame_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_ss_scan_mux.sv
// Self-checking bench for ss_scan_mux: cycle-count reference model, decode table and
// hand-written frame-boundary, double-load and reset sequences.
module tb_ss_scan_mux;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * R;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic [7:0]  sseg_o;
  logic [3:0]  an_o;
  logic        frame_o;
  logic        pending_o;

  ss_scan_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYC   (B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_i),
    .data_i    (data_i),
    .dp_i      (dp_i),
    .sseg_o    (sseg_o),
    .an_o      (an_o),
    .frame_o   (frame_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       dp;
    logic [7:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ref_seg [16];

  // Reference state: position in the scan is derived from cycles since reset.
  int          m_cyc;
  logic [15:0] m_data, m_sh;
  logic [3:0]  m_dp, m_shdp;
  logic        m_pend;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_data = '0;
    m_sh   = '0;
    m_dp   = '0;
    m_shdp = '0;
    m_pend = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
    int         pos, dig;
    logic [3:0] nib, e_an;
    logic [7:0] e_seg;
    logic       e_frame;
    logic       bnd;
    load_i = ld;
    data_i = d;
    dp_i   = p;
    pos = m_cyc % R;
    dig = (m_cyc / R) % N;
    if (pos < B) begin
      e_an  = 4'hF;
      e_seg = 8'hFF;
    end else begin
      e_an  = ~(4'b0001 << dig);
      nib   = 4'((m_data >> (4 * dig)) & 16'hF);
      e_seg = ref_seg[nib];
      if (m_dp[dig]) e_seg = e_seg & 8'h7F;
    end
    bnd     = (m_cyc % FRAME) == FRAME - 1;
    e_frame = bnd;
    if (ld && bnd) begin
      m_data = d;
      m_dp   = p;
      m_pend = 1'b0;
    end else if (ld) begin
      m_sh   = d;
      m_shdp = p;
      m_pend = 1'b1;
    end else if (bnd && m_pend) begin
      m_data = m_sh;
      m_dp   = m_shdp;
      m_pend = 1'b0;
    end
    m_cyc++;
    @(posedge clk);
    #1;
    load_i = 1'b0;
    chk("an_o", 16'(an_o), 16'(e_an));
    chk("sseg_o", 16'(sseg_o), 16'(e_seg));
    chk("frame_o", 16'(frame_o), 16'(e_frame));
    chk("pending_o", 16'(pending_o), 16'(m_pend));
    chk("an_onehot", 16'($countones(~an_o) <= 1), 16'd1);
  endtask

  task automatic goto_pos(input int pos);
    while ((m_cyc % FRAME) != pos) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic chk_blank(input string name);
    chk({name, "_sseg"}, 16'(sseg_o), 16'h00FF);
    chk({name, "_an"}, 16'(an_o), 16'h000F);
    chk({name, "_frame"}, 16'(frame_o), 16'h0);
    chk({name, "_pend"}, 16'(pending_o), 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tab [20];
    logic [7:0] s2_exp [4];
    logic [7:0] s3_exp [4];
    logic       ld;
    int         nf;

`ifdef SS_HEX_EN
    ref_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`else
    ref_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
    for (int i = 0; i < 16; i++) begin
      tab[i].code = 4'(i);
      tab[i].dp   = 1'b0;
      tab[i].exp  = ref_seg[i];
    end
    tab[16].code = 4'h8; tab[16].dp = 1'b1; tab[16].exp = 8'h00;
    tab[17].code = 4'h0; tab[17].dp = 1'b1; tab[17].exp = 8'h40;
`ifdef SS_HEX_EN
    tab[18].code = 4'hB; tab[18].dp = 1'b1; tab[18].exp = 8'h03;
    tab[19].code = 4'hF; tab[19].dp = 1'b1; tab[19].exp = 8'h0E;
`else
    tab[18].code = 4'hB; tab[18].dp = 1'b1; tab[18].exp = 8'h7F;
    tab[19].code = 4'hF; tab[19].dp = 1'b1; tab[19].exp = 8'h7F;
`endif
    s2_exp = '{8'h99, 8'h30, 8'hA4, 8'hF9};
    s3_exp = '{8'h80, 8'hF8, 8'h82, 8'h92};

    rst_n  = 1'b0;
    load_i = 1'b0;
    data_i = '0;
    dp_i   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_blank("reset");
    rst_n = 1'b1;

    // Idle scan: digit order, blanking and frame period.
    goto_pos(2);
    step(1'b0, 16'h0, 4'h0);
    chk("s1_d0_an", 16'(an_o), 16'h000E);
    chk("s1_d0_seg", 16'(sseg_o), 16'h00C0);
    goto_pos(10);
    step(1'b0, 16'h0, 4'h0);
    chk("s1_d1_an", 16'(an_o), 16'h000D);
    goto_pos(18);
    step(1'b0, 16'h0, 4'h0);
    chk("s1_d2_an", 16'(an_o), 16'h000B);
    goto_pos(26);
    step(1'b0, 16'h0, 4'h0);
    chk("s1_d3_an", 16'(an_o), 16'h0007);
    goto_pos(0);
    nf = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 16'h0, 4'h0);
      if (frame_o) nf++;
    end
    chk("s1_frame_count", 16'(nf), 16'd2);

    // Mid-frame load waits for the boundary.
    goto_pos(10);
    step(1'b1, 16'h1234, 4'b0010);
    chk("s2_pending_set", 16'(pending_o), 16'h1);
    goto_pos(31);
    step(1'b0, 16'h0, 4'h0);
    chk("s2_pending_clr", 16'(pending_o), 16'h0);
    chk("s2_frame", 16'(frame_o), 16'h1);
    for (int k = 0; k < N; k++) begin
      goto_pos(8 * k + 2);
      step(1'b0, 16'h0, 4'h0);
      chk("s2_digit", 16'(sseg_o), 16'(s2_exp[k]));
    end

    // Two loads in one frame: last wins.
    goto_pos(5);
    step(1'b1, 16'h1111, 4'h0);
    goto_pos(12);
    step(1'b1, 16'h5678, 4'h0);
    goto_pos(0);
    for (int k = 0; k < N; k++) begin
      goto_pos(8 * k + 2);
      step(1'b0, 16'h0, 4'h0);
      chk("s3_digit", 16'(sseg_o), 16'(s3_exp[k]));
    end

    // Load on the boundary cycle goes straight to the display.
    goto_pos(31);
    step(1'b1, 16'h4321, 4'h0);
    chk("s4_pending", 16'(pending_o), 16'h0);
    step(1'b0, 16'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    chk("s4_an", 16'(an_o), 16'h000E);
    chk("s4_seg", 16'(sseg_o), 16'h00F9);

    // Decode table, all digits loaded on a boundary.
    for (int i = 0; i < 20; i++) begin
      goto_pos(31);
      step(1'b1, {4{tab[i].code}}, {4{tab[i].dp}});
      goto_pos(2);
      step(1'b0, 16'h0, 4'h0);
      chk("table_seg", 16'(sseg_o), 16'(tab[i].exp));
    end

    // Randomised loads.
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      step(ld, 16'($urandom), 4'($urandom));
    end

    // Reset mid-slot while pending.
    goto_pos(3);
    step(1'b1, 16'h8888, 4'hF);
    goto_pos(14);
    chk("s6_pending_before", 16'(pending_o), 16'h1);
    rst_n = 1'b0;
    #1;
    chk_blank("s6_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_blank("s6_held");
    end
    rst_n = 1'b1;
    model_reset();
    goto_pos(2);
    step(1'b0, 16'h0, 4'h0);
    chk("s6_restart_an", 16'(an_o), 16'h000E);
    chk("s6_restart_seg", 16'(sseg_o), 16'h00C0);
    chk("s6_restart_pend", 16'(pending_o), 16'h0);
    for (int i = 0; i < FRAME + 8; i++) step(1'b0, 16'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
